// File: rtl/sadd_sched.sv
// Two-requester round-robin scheduler around a 2-bit-per-cycle serial adder.
// A granted operation runs W/2 slice cycles, then presents s/co/id with a done pulse.
module sadd_sched #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         id,
  output logic [W-1:0] s,
  output logic         co
);

  localparam int unsigned NSL   = W / 2;
  localparam int unsigned CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             id_q, id_d;
  logic [W-1:0]     s_q, s_d;
  logic             co_q, co_d;

  logic             grant_c;
  logic             any_req_c;
  logic [CNT_W:0]   base_c;
  logic [2:0]       slice_sum_c;

  // Both requesting: pointer decides; otherwise whoever is asking.
  assign any_req_c = req0 | req1;
  assign grant_c   = (req0 & req1) ? ptr_q : req1;

  // Current 2-bit slice of the captured operands plus running carry.
  assign base_c      = {cnt_q, 1'b0};
  assign slice_sum_c = 3'(2'(a_q >> base_c)) + 3'(2'(b_q >> base_c)) + 3'(carry_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req_c) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    id_d    = id_q;
    s_d     = s_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          owner_d = grant_c;
          ptr_d   = ~grant_c;
          a_d     = grant_c ? a1 : a0;
          b_d     = grant_c ? b1 : b0;
          psum_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          gnt0_d  = ~grant_c;
          gnt1_d  = grant_c;
        end
      end
      RUN: begin
        psum_d[base_c +: 2] = slice_sum_c[1:0];
        carry_d             = slice_sum_c[2];
        cnt_d               = cnt_q + CNT_W'(1);
        // Final slice: publish the completed result as DONE is entered.
        if (cnt_q == CNT_LAST) begin
          s_d    = psum_d;
          co_d   = slice_sum_c[2];
          id_d   = owner_q;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_q    <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      id_q    <= id_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;
  assign done = done_q;
  assign id   = id_q;
  assign s    = s_q;
  assign co   = co_q;

endmodule

// File: tb/tb_sadd_sched.sv
// Directed bench for sadd_sched (W=8): latency, arbitration, reset abort, operand isolation.
module tb_sadd_sched;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, done, id, co;
  logic [7:0] s;

  int checks = 0;
  int errors = 0;

  sadd_sched #(.W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .a0   (a0),
    .b0   (b0),
    .req1 (req1),
    .a1   (a1),
    .b1   (b1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .busy (busy),
    .done (done),
    .id   (id),
    .s    (s),
    .co   (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: grant in cycle 1, done in cycle 5, idle from cycle 6.
  task automatic op(input bit who, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] exp_s, input bit exp_co,
                    input bit mutate, input bit spur);
    if (!who) begin req0 = 1'b1; a0 = a; b0 = b; end
    else      begin req1 = 1'b1; a1 = a; b1 = b; end
    tick();
    chk("gnt0_c1", gnt0, 32'(!who));
    chk("gnt1_c1", gnt1, 32'(who));
    chk("busy_c1", busy, 1);
    chk("done_c1", done, 0);
    req0 = 1'b0;
    req1 = 1'b0;
    if (mutate) begin
      if (!who) begin a0 = 8'hF0; b0 = 8'hEE; end
      else      begin a1 = 8'hF0; b1 = 8'hEE; end
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (spur && c == 2) begin
        if (!who) req1 = 1'b1; else req0 = 1'b1;
      end
      if (c == 4) begin req0 = 1'b0; req1 = 1'b0; end
      chk($sformatf("done_c%0d", c), done, 0);
      chk($sformatf("gnt_c%0d", c), {gnt1, gnt0}, 0);
      chk($sformatf("busy_c%0d", c), busy, 1);
    end
    tick();
    chk("done_c5", done, 1);
    chk("s_c5", s, exp_s);
    chk("co_c5", co, 32'(exp_co));
    chk("id_c5", id, 32'(who));
    chk("busy_c5", busy, 1);
    tick();
    chk("done_c6", done, 0);
    chk("busy_c6", busy, 0);
    chk("s_hold_c6", s, exp_s);
    tick();
    chk("gnt_c7", {gnt1, gnt0}, 0);
    chk("busy_c7", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    tick();
    tick();
    chk("rst_s", s, 0);
    chk("rst_co", co, 0);
    chk("rst_id", id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    rst = 1'b0;

    // Basic adds, carry ripple, operand isolation, withdrawn request
    op(1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b0, 1'b1);
    op(1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    op(1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b0);
    op(1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
    op(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0);

    // Both requesters held: grants alternate starting at 0, done every 6 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; a0 = 8'h10; b0 = 8'h20;
    req1 = 1'b1; a1 = 8'h0F; b1 = 8'hF1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      chk($sformatf("rr_gnt0@%0d", c), gnt0, 32'(c == 1 || c == 13));
      chk($sformatf("rr_gnt1@%0d", c), gnt1, 32'(c == 7 || c == 19));
      chk($sformatf("rr_done@%0d", c), done, 32'(c == 5 || c == 11 || c == 17 || c == 23));
      if (c == 5 || c == 17) begin
        chk($sformatf("rr_id@%0d", c), id, 0);
        chk($sformatf("rr_s@%0d", c), s, 32'h30);
        chk($sformatf("rr_co@%0d", c), co, 0);
      end
      if (c == 11 || c == 23) begin
        chk($sformatf("rr_id@%0d", c), id, 1);
        chk($sformatf("rr_s@%0d", c), s, 32'h00);
        chk($sformatf("rr_co@%0d", c), co, 1);
      end
      if (c == 24) begin req0 = 1'b0; req1 = 1'b0; end
    end
    tick();

    // Leave pointer at 1 and a nonzero result, then abort an op with reset
    op(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
    req0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
    tick();
    chk("ab_gnt0_c1", gnt0, 1);
    req0 = 1'b0;
    tick();
    tick();
    chk("ab_busy_c3", busy, 1);
    rst = 1'b1;
    tick();
    chk("ab_busy_c4", busy, 0);
    chk("ab_s_c4", s, 0);
    chk("ab_co_c4", co, 0);
    chk("ab_done_c4", done, 0);
    // Request right after reset falls; pointer was reset to 0
    rst = 1'b0;
    req0 = 1'b1; a0 = 8'h21; b0 = 8'h43;
    req1 = 1'b1; a1 = 8'h99; b1 = 8'h99;
    tick();
    chk("post_gnt0", gnt0, 1);
    chk("post_gnt1", gnt1, 0);
    chk("post_done", done, 0);
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("post_nodone_c%0d", c), done, 0);
    end
    tick();
    chk("post_done_c5", done, 1);
    chk("post_s_c5", s, 32'h64);
    chk("post_id_c5", id, 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sadd_sched.md
SADD_SCHED -- requirements
Module: sadd_sched

Interface
REQ-001 Parameter: W, default 8, operand/sum width in bits; SHALL be even and >= 2.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: req0  in  1  requester 0 asks for an addition; held high until gnt0 is seen.
REQ-005 Port: a0, b0  in  W  requester 0 operands; valid while req0 is high.
REQ-006 Port: req1  in  1  requester 1 request, same rules as req0.
REQ-007 Port: a1, b1  in  W  requester 1 operands.
REQ-008 Port: gnt0, gnt1  out  1  one-cycle pulse; operands of that requester were captured.
REQ-009 Port: busy  out  1  high while an operation is in progress (RUN or DONE).
REQ-010 Port: done  out  1  one-cycle pulse; s, co and id are newly valid.
REQ-011 Port: id  out  1  requester that owns the current result (0 or 1).
REQ-012 Port: s  out  W  registered sum of the last completed operation.
REQ-013 Port: co  out  1  registered carry-out of the last completed operation.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; there are no other states.
REQ-015 In IDLE with neither request high, the FSM SHALL stay in IDLE.
REQ-016 In IDLE with at least one request high, the block SHALL:
- select one requester per REQ-017;
- capture its a/b into internal operand registers;
- clear the carry register and the slice counter;
- move to RUN;
- assert the matching gnt for exactly the first RUN cycle.
REQ-017 Arbitration SHALL be round-robin using a 1-bit priority pointer:
- both requests high: grant the requester the pointer names;
- one request high: grant it;
- after any grant, the pointer names the other requester.
REQ-018 Each RUN cycle k (k = 0 .. W/2-1) SHALL:
- add captured bits [2k+1:2k] of a, the same bits of b, and the carry register;
- write the 2-bit sum into bits [2k+1:2k] of an internal partial-sum register;
- store the carry out of that slice in the carry register.
REQ-019 RUN SHALL last exactly W/2 cycles; after slice W/2-1 the FSM SHALL enter DONE.
REQ-020 On entry to DONE, the block SHALL load s from the partial sum, co from the final carry and id from the granted requester.
- These values SHALL hold until the next DONE entry or reset.
REQ-021 done SHALL be high for exactly the single DONE cycle; the FSM then SHALL return to IDLE unconditionally.
REQ-022 Latency: a request sampled at edge E gives gnt in cycle E+1 and done in cycle E+1+W/2.
- Throughput SHALL be one operation per W/2+2 cycles.
REQ-023 Changes on a/b/req after grant SHALL NOT affect the running operation.
REQ-024 A req dropped before its grant is withdrawn; no grant SHALL be issued for it.
- A req still high in the next IDLE SHALL be treated as a new request.
REQ-025 s and co SHALL equal (a + b) mod 2^W and bit W of a + b respectively, for all operand values.

Reset
REQ-026 With rst high at a clock edge, the block SHALL set: FSM = IDLE, pointer = 0, s = 0, co = 0, id = 0, busy = 0, done = 0, gnt0 = gnt1 = 0.
- Internal operand, partial-sum, carry and counter registers SHALL clear to 0.
REQ-027 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-028 A request high in the first cycle after rst falls SHALL be served normally.

Verification (W=8)
REQ-029 req0, a0=0x5A, b0=0x33 -> gnt0 in cycle 1; done in cycle 5 with s=0x8D, co=0, id=0.
REQ-030 req1, a1=0xFF, b1=0x01 -> done with s=0x00, co=1, id=1 (carry ripples through all 4 slices).
REQ-031 a0=0xAA, b0=0x55 -> s=0xFF, co=0; then a0=0x80, b0=0x80 -> s=0x00, co=1.
REQ-032 After reset, req0 and req1 held high continuously -> grants alternate 0,1,0,1 with ids matching; done pulses spaced 6 cycles apart.
REQ-033 rst pulsed in the 3rd RUN cycle -> next cycle busy=0, s=0, co=0; no done appears; the next grant goes to requester 0.
REQ-034 a0 changed from 0x01 to 0xF0 one cycle after gnt0, with b0=0x01 -> s=0x02, co=0.
